// File: rtl/ahb_lite_arbiter.sv
// ahb_lite_arbiter: round-robin AHB-Lite bus arbiter.
// Hands over only at transfer boundaries; separate address/data muxes.
module ahb_lite_arbiter #(
   parameter int NUM_M      = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MW         = $clog2(NUM_M)
) (
   input  logic                        hclock,
   input  logic                        hreset,
   input  logic [NUM_M-1:0]            m_hbusreq,
   input  logic [NUM_M-1:0]            m_hlock,
   input  logic [NUM_M*ADDR_WIDTH-1:0] m_haddr,
   input  logic [NUM_M*2-1:0]          m_htrans,
   input  logic [NUM_M-1:0]            m_hwrite,
   input  logic [NUM_M*3-1:0]          m_hsize,
   input  logic [NUM_M*3-1:0]          m_hburst,
   input  logic [NUM_M*4-1:0]          m_hprot,
   input  logic [NUM_M*DATA_WIDTH-1:0] m_hwdata,
   input  logic                        hready,
   output logic [NUM_M-1:0]            hgrant,
   output logic [MW-1:0]               hmaster,
   output logic [MW-1:0]               hmaster_data,
   output logic [ADDR_WIDTH-1:0]       haddr,
   output logic [1:0]                  htrans,
   output logic                        hwrite,
   output logic [2:0]                  hsize,
   output logic [2:0]                  hburst,
   output logic [3:0]                  hprot,
   output logic                        hmastlock,
   output logic [DATA_WIDTH-1:0]       hwdata
);

   localparam logic [1:0]       TR_BUSY = 2'b01;
   localparam logic [1:0]       TR_SEQ  = 2'b11;
   localparam logic [NUM_M-1:0] GNT0    = NUM_M'(1);

   logic [ADDR_WIDTH-1:0] a_s [NUM_M];
   logic [1:0]            t_s [NUM_M];
   logic [2:0]            s_s [NUM_M];
   logic [2:0]            b_s [NUM_M];
   logic [3:0]            p_s [NUM_M];
   logic [DATA_WIDTH-1:0] d_s [NUM_M];

   logic [MW-1:0] rr_ptr;
   logic [MW-1:0] winner;
   logic [MW-1:0] nxt_ptr;
   logic          found;
   logic          hmastlock_next;
   logic          rearb_ok;

   for (genvar i = 0; i < NUM_M; i++) begin : g_slice
      assign a_s[i] = m_haddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign t_s[i] = m_htrans[i*2 +: 2];
      assign s_s[i] = m_hsize[i*3 +: 3];
      assign b_s[i] = m_hburst[i*3 +: 3];
      assign p_s[i] = m_hprot[i*4 +: 4];
      assign d_s[i] = m_hwdata[i*DATA_WIDTH +: DATA_WIDTH];
   end

   // address phase follows hmaster, data phase follows hmaster_data
   always_comb begin
      haddr  = a_s[hmaster];
      htrans = t_s[hmaster];
      hwrite = m_hwrite[hmaster];
      hsize  = s_s[hmaster];
      hburst = b_s[hmaster];
      hprot  = p_s[hmaster];
      hwdata = d_s[hmaster_data];
   end

   // handover allowed only outside bursts, stalls and locked sequences
   always_comb begin
      hmastlock_next = m_hlock[hmaster] & m_hbusreq[hmaster];
      rearb_ok = hready & (htrans != TR_SEQ) & (htrans != TR_BUSY)
                 & ~hmastlock_next;
   end

   // first requester at or after rr_ptr, wrapping modulo NUM_M
   always_comb begin
      logic [MW-1:0] sel;
      found  = 1'b0;
      winner = hmaster;
      sel    = '0;
      for (int k = 0; k < NUM_M; k++) begin
         sel = MW'((int'(rr_ptr) + k) % NUM_M);
         if (!found && m_hbusreq[sel]) begin
            found  = 1'b1;
            winner = sel;
         end
      end
      nxt_ptr = (winner == MW'(NUM_M-1)) ? '0 : winner + 1'b1;
   end

   // ownership and pointer advance on a boundary with a requester
   always_ff @(posedge hclock or posedge hreset) begin
      if (hreset) begin
         hgrant  <= GNT0;
         hmaster <= '0;
         rr_ptr  <= '0;
      end else if (rearb_ok && found) begin
         hgrant  <= GNT0 << winner;
         hmaster <= winner;
         rr_ptr  <= nxt_ptr;
      end
   end

   // data-phase owner and lock advance with the bus pipeline
   always_ff @(posedge hclock or posedge hreset) begin
      if (hreset) begin
         hmaster_data <= '0;
         hmastlock    <= 1'b0;
      end else if (hready) begin
         hmaster_data <= hmaster;
         hmastlock    <= hmastlock_next;
      end
   end

endmodule
